// File: rtl/alu_mc_pkg.sv
// Shared definitions for the multi-cycle execute-stage ALU.
// Defines the operation codes (alu_op_e), the handshake FSM states
// (state_e), and small decode helpers that classify an operation code
// for the iterative multiply/divide unit. Operation codes arrive as raw
// 5-bit values, so the helpers take logic [4:0]. Undefined codes 18..31
// are then decoded without any out-of-range enum casts.
package alu_mc_pkg;

  typedef enum logic [4:0] {
    OP_ADD    = 5'd0,
    OP_SUB    = 5'd1,
    OP_AND    = 5'd2,
    OP_OR     = 5'd3,
    OP_XOR    = 5'd4,
    OP_SLT    = 5'd5,
    OP_SLTU   = 5'd6,
    OP_SLL    = 5'd7,
    OP_SRL    = 5'd8,
    OP_SRA    = 5'd9,
    OP_MUL    = 5'd10,
    OP_MULH   = 5'd11,
    OP_MULHSU = 5'd12,
    OP_MULHU  = 5'd13,
    OP_DIV    = 5'd14,
    OP_DIVU   = 5'd15,
    OP_REM    = 5'd16,
    OP_REMU   = 5'd17
  } alu_op_e;

  typedef enum logic [1:0] {
    IDLE,
    BUSY,
    DONE
  } state_e;

  function automatic logic is_mul(input logic [4:0] op);
    return (op == OP_MUL) || (op == OP_MULH) || (op == OP_MULHSU) || (op == OP_MULHU);
  endfunction

  function automatic logic is_div(input logic [4:0] op);
    return (op == OP_DIV) || (op == OP_DIVU) || (op == OP_REM) || (op == OP_REMU);
  endfunction

  function automatic logic is_signed_a(input logic [4:0] op);
    return (op == OP_MUL) || (op == OP_MULH) || (op == OP_MULHSU) ||
           (op == OP_DIV) || (op == OP_REM);
  endfunction

  function automatic logic is_signed_b(input logic [4:0] op);
    return (op == OP_MUL) || (op == OP_MULH) || (op == OP_DIV) || (op == OP_REM);
  endfunction

endpackage

// File: rtl/mdu_iter.sv
// Iterative radix-2 multiply/divide datapath, one bit per cycle.
// Ports:
//   clk, rst_n  clock and synchronous active-low reset
//   flush       abandon the operation in progress
//   start       load operands and begin XLEN iterations
//   op, a, b    operation code and operands, sampled on start
//   done        high during the final iteration cycle
//   res         sign-corrected final value, valid while done is high
// The unit works on operand magnitudes and applies the sign at the end.
// Multiply: {hi,lo} starts as {0, |b|}; each step adds |a| to hi when
// lo[0] is set, then shifts right. Divide: {rem,quo} starts as {0, |a|};
// each step shifts left and subtracts |b| if the remainder allows it.
module mdu_iter
  import alu_mc_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            flush,
  input  logic            start,
  input  logic [4:0]      op,
  input  logic [XLEN-1:0] a,
  input  logic [XLEN-1:0] b,
  output logic            done,
  output logic [XLEN-1:0] res
);

  localparam int CW = $clog2(XLEN) + 1;

  logic [2*XLEN-1:0] acc;
  logic [XLEN-1:0]   opd;
  logic [CW-1:0]     cnt;
  logic              running;
  logic              mul_mode;
  logic              hi_sel;
  logic              rem_sel;
  logic              neg_main;
  logic              neg_rem;

  logic              sa, sb;
  logic [XLEN-1:0]   ma, mb;
  logic [XLEN:0]     mul_sum;
  logic [XLEN:0]     rem_shift;
  logic [XLEN:0]     div_diff;
  logic [2*XLEN-1:0] acc_next;
  logic [2*XLEN-1:0] prod;
  logic [XLEN-1:0]   quo, remv;

  assign sa = is_signed_a(op) & a[XLEN-1];
  assign sb = is_signed_b(op) & b[XLEN-1];
  assign ma = sa ? -a : a;
  assign mb = sb ? -b : b;

  // One iteration step for whichever operation is loaded. The carry out of
  // mul_sum becomes the new top bit after the right shift. div_diff bit
  // XLEN is set exactly when the trial subtraction went negative.
  always_comb begin
    mul_sum   = {1'b0, acc[2*XLEN-1:XLEN]} + (acc[0] ? {1'b0, opd} : '0);
    rem_shift = {acc[2*XLEN-1:XLEN], acc[XLEN-1]};
    div_diff  = rem_shift - {1'b0, opd};
    acc_next  = '0;
    if (mul_mode) begin
      acc_next = {mul_sum, acc[XLEN-1:1]};
    end else if (div_diff[XLEN]) begin
      acc_next = {rem_shift[XLEN-1:0], acc[XLEN-2:0], 1'b0};
    end else begin
      acc_next = {div_diff[XLEN-1:0], acc[XLEN-2:0], 1'b1};
    end
  end

  // Sign correction applied to the value the final iteration produces.
  always_comb begin
    prod = neg_main ? -acc_next : acc_next;
    quo  = acc_next[XLEN-1:0];
    remv = acc_next[2*XLEN-1:XLEN];
    if (mul_mode) begin
      res = hi_sel ? prod[2*XLEN-1:XLEN] : prod[XLEN-1:0];
    end else if (rem_sel) begin
      res = neg_rem ? -remv : remv;
    end else begin
      res = neg_main ? -quo : quo;
    end
  end

  assign done = running && (cnt == CW'(1));

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      acc      <= '0;
      opd      <= '0;
      cnt      <= '0;
      running  <= 1'b0;
      mul_mode <= 1'b0;
      hi_sel   <= 1'b0;
      rem_sel  <= 1'b0;
      neg_main <= 1'b0;
      neg_rem  <= 1'b0;
    end else if (flush) begin
      running <= 1'b0;
      cnt     <= '0;
    end else if (start) begin
      running  <= 1'b1;
      cnt      <= CW'(XLEN);
      mul_mode <= is_mul(op);
      hi_sel   <= (op != OP_MUL);
      rem_sel  <= (op == OP_REM) || (op == OP_REMU);
      neg_main <= sa ^ sb;
      neg_rem  <= sa;
      if (is_mul(op)) begin
        acc <= {{XLEN{1'b0}}, mb};
        opd <= ma;
      end else begin
        acc <= {{XLEN{1'b0}}, ma};
        opd <= mb;
      end
    end else if (running) begin
      acc <= acc_next;
      cnt <= cnt - CW'(1);
      if (cnt == CW'(1)) begin
        running <= 1'b0;
      end
    end
  end

endmodule

// File: rtl/alu_mc.sv
// Multi-cycle execute-stage ALU with valid/ready handshakes on both sides.
// Ports:
//   clk, rst_n            clock and synchronous active-low reset
//   in_valid, in_ready    request handshake (in_ready high only in IDLE)
//   op, a, b              operation code and operands, latched on accept
//   flush                 abort whatever is in flight
//   out_valid, out_ready  result handshake
//   result                registered result
//   busy                  an iterative multiply/divide is in progress
// Base operations complete in one cycle. Division by zero and the signed
// overflow case also complete in one cycle, because their answers are
// fixed. Every other multiply or divide runs through mdu_iter.
module alu_mc
  import alu_mc_pkg::*;
#(
  parameter  int XLEN = 32,
  localparam int SHW  = $clog2(XLEN)
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [4:0]      op,
  input  logic [XLEN-1:0] a,
  input  logic [XLEN-1:0] b,
  input  logic            flush,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] result,
  output logic            busy
);

  localparam logic [XLEN-1:0] MIN_NEG = {1'b1, {(XLEN-1){1'b0}}};

  state_e          state;
  logic [SHW-1:0]  shamt;
  logic [XLEN-1:0] base_res;
  logic            div_zero;
  logic            div_ovf;
  logic            needs_iter;
  logic            mdu_start;
  logic            mdu_done;
  logic [XLEN-1:0] mdu_res;

  assign shamt      = b[SHW-1:0];
  assign div_zero   = is_div(op) && (b == '0);
  assign div_ovf    = ((op == OP_DIV) || (op == OP_REM)) && (a == MIN_NEG) && (b == '1);
  assign needs_iter = is_mul(op) || (is_div(op) && !div_zero && !div_ovf);
  assign mdu_start  = (state == IDLE) && in_valid && !flush && needs_iter;

  // Single-cycle results. The divide entries only matter for the fixed
  // corner cases; the iterative path supplies every other divide result.
  always_comb begin
    base_res = '0;
    case (op)
      OP_ADD:  base_res = a + b;
      OP_SUB:  base_res = a - b;
      OP_AND:  base_res = a & b;
      OP_OR:   base_res = a | b;
      OP_XOR:  base_res = a ^ b;
      OP_SLT:  base_res = {{(XLEN-1){1'b0}}, $signed(a) < $signed(b)};
      OP_SLTU: base_res = {{(XLEN-1){1'b0}}, a < b};
      OP_SLL:  base_res = a << shamt;
      OP_SRL:  base_res = a >> shamt;
      OP_SRA:  base_res = $signed(a) >>> shamt;
      OP_DIV, OP_DIVU: begin
        if (div_zero)     base_res = '1;
        else if (div_ovf) base_res = a;
      end
      OP_REM, OP_REMU: begin
        if (div_zero)     base_res = a;
        else if (div_ovf) base_res = '0;
      end
      default: base_res = '0;
    endcase
  end

  mdu_iter #(
    .XLEN(XLEN)
  ) u_mdu (
    .clk  (clk),
    .rst_n(rst_n),
    .flush(flush),
    .start(mdu_start),
    .op   (op),
    .a    (a),
    .b    (b),
    .done (mdu_done),
    .res  (mdu_res)
  );

  // Handshake FSM with registered outputs. Flush takes priority over any
  // accept or result handoff in the same cycle.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= IDLE;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      busy      <= 1'b0;
      result    <= '0;
    end else if (flush) begin
      state     <= IDLE;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      busy      <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            in_ready <= 1'b0;
            if (needs_iter) begin
              state <= BUSY;
              busy  <= 1'b1;
            end else begin
              state     <= DONE;
              result    <= base_res;
              out_valid <= 1'b1;
            end
          end
        end
        BUSY: begin
          if (mdu_done) begin
            state     <= DONE;
            result    <= mdu_res;
            out_valid <= 1'b1;
            busy      <= 1'b0;
          end
        end
        DONE: begin
          if (out_ready) begin
            state     <= IDLE;
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
          end
        end
        default: begin
          state     <= IDLE;
          in_ready  <= 1'b1;
          out_valid <= 1'b0;
          busy      <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_alu_mc.sv
// Self-checking bench for alu_mc (XLEN=32). Expected results are queued
// when a request is accepted and compared when the result handshake fires.
module tb_alu_mc;
  import alu_mc_pkg::*;

  typedef struct {
    string       tag;
    logic [31:0] v;
  } sb_t;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [4:0]  op;
  logic [31:0] a;
  logic [31:0] b;
  logic        flush;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] result;
  logic        busy;

  sb_t expq[$];
  int  compared   = 0;
  int  mismatched = 0;

  alu_mc #(
    .XLEN(32)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .op       (op),
    .a        (a),
    .b        (b),
    .flush    (flush),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .result   (result),
    .busy     (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    compared++;
    if (got !== exp) begin
      mismatched++;
      $display("[TB] FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Reference model built on native arithmetic.
  function automatic logic [31:0] modelOp(input logic [4:0] o, input logic [31:0] x, input logic [31:0] y);
    int          xi, yi;
    longint      sx, sy, p;
    logic [63:0] u;
    xi = x;
    yi = y;
    sx = xi;
    sy = yi;
    case (o)
      OP_MUL:    begin p = sx * sy; return p[31:0]; end
      OP_MULH:   begin p = sx * sy; return p[63:32]; end
      OP_MULHSU: begin p = sx * longint'({32'b0, y}); return p[63:32]; end
      OP_MULHU:  begin u = {32'b0, x} * {32'b0, y}; return u[63:32]; end
      OP_DIV: begin
        if (y == 32'd0) return 32'hFFFF_FFFF;
        if (x == 32'h8000_0000 && y == 32'hFFFF_FFFF) return x;
        return xi / yi;
      end
      OP_DIVU:   return (y == 32'd0) ? 32'hFFFF_FFFF : x / y;
      OP_REM: begin
        if (y == 32'd0) return x;
        if (x == 32'h8000_0000 && y == 32'hFFFF_FFFF) return 32'd0;
        return xi % yi;
      end
      OP_REMU:   return (y == 32'd0) ? x : x % y;
      default:   return 32'd0;
    endcase
  endfunction

  function automatic int modelLat(input logic [4:0] o, input logic [31:0] x, input logic [31:0] y);
    if (o >= 5'd10 && o <= 5'd13) return 33;
    if (o >= 5'd14 && o <= 5'd17) begin
      if (y == 32'd0) return 1;
      if ((o == OP_DIV || o == OP_REM) && x == 32'h8000_0000 && y == 32'hFFFF_FFFF) return 1;
      return 33;
    end
    return 1;
  endfunction

  // Issue one request, queue its expected result, then measure latency and
  // busy behaviour up to the cycle in which out_valid rises.
  task automatic applyStimulus(input logic [4:0] o, input logic [31:0] x, input logic [31:0] y,
                               input logic [31:0] exp, input int lat, input logic rdy);
    int  n;
    int  busy_bad;
    sb_t e;
    @(posedge clk); #1;
    op = o; a = x; b = y; in_valid = 1'b1; out_ready = rdy;
    @(negedge clk);
    checkOutput($sformatf("in_ready_op%0d", o), 32'(in_ready), 32'd1);
    @(posedge clk);
    e.tag = $sformatf("result_op%0d_%h_%h", o, x, y);
    e.v   = exp;
    expq.push_back(e);
    #1;
    in_valid = 1'b0; op = 5'($urandom); a = $urandom; b = $urandom;
    n = 0;
    busy_bad = 0;
    do begin
      @(negedge clk);
      n++;
      if (!out_valid && (busy !== (lat > 1))) busy_bad++;
    end while (!out_valid && n < 100);
    if (busy !== 1'b0) busy_bad++;
    checkOutput($sformatf("latency_op%0d", o), 32'(n), 32'(lat));
    checkOutput($sformatf("busy_op%0d", o), 32'(busy_bad), 32'd0);
  endtask

  // Scoreboard: pop and compare whenever the result handshake will be taken.
  always @(negedge clk) begin
    if (rst_n && out_valid && out_ready && !flush) begin
      if (expq.size() == 0) begin
        checkOutput("unexpected_out_valid", 32'(out_valid), 32'd0);
      end else begin
        sb_t e;
        e = expq.pop_front();
        checkOutput(e.tag, result, e.v);
      end
    end
  end

  initial begin
    #300000;
    $display("[TB] FAIL watchdog: got timeout expected finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int bad;
    logic [4:0]  o;
    logic [31:0] x, y;

    rst_n = 1'b0; in_valid = 1'b0; flush = 1'b0; out_ready = 1'b1;
    op = 5'd0; a = 32'd0; b = 32'd0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    checkOutput("reset_in_ready", 32'(in_ready), 32'd1);
    checkOutput("reset_out_valid", 32'(out_valid), 32'd0);
    checkOutput("reset_busy", 32'(busy), 32'd0);
    checkOutput("reset_result", result, 32'd0);
    @(posedge clk); #1 rst_n = 1'b1;

    // Base operations
    applyStimulus(OP_ADD,  32'h7FFF_FFFF, 32'd1,         32'h8000_0000, 1, 1'b1);
    applyStimulus(OP_SUB,  32'd5,         32'd7,         32'hFFFF_FFFE, 1, 1'b1);
    applyStimulus(OP_AND,  32'hF0F0_F0F0, 32'hFF00_FF00, 32'hF000_F000, 1, 1'b1);
    applyStimulus(OP_OR,   32'hF0F0_F0F0, 32'hFF00_FF00, 32'hFFF0_FFF0, 1, 1'b1);
    applyStimulus(OP_XOR,  32'hF0F0_F0F0, 32'hFF00_FF00, 32'h0FF0_0FF0, 1, 1'b1);
    applyStimulus(OP_SLT,  32'hFFFF_FFFF, 32'd1,         32'd1,         1, 1'b1);
    applyStimulus(OP_SLTU, 32'hFFFF_FFFF, 32'd1,         32'd0,         1, 1'b1);
    applyStimulus(OP_SLL,  32'd1,         32'h0000_0023, 32'd8,         1, 1'b1);
    applyStimulus(OP_SRL,  32'h8000_0000, 32'd4,         32'h0800_0000, 1, 1'b1);
    applyStimulus(OP_SRA,  32'h8000_0000, 32'd4,         32'hF800_0000, 1, 1'b1);
    applyStimulus(5'd20,   32'h1234_5678, 32'd9,         32'd0,         1, 1'b1);

    // Iterative multiply / divide
    applyStimulus(OP_MULH,   32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0000, 33, 1'b1);
    applyStimulus(OP_MULHU,  32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 33, 1'b1);
    applyStimulus(OP_MUL,    32'd7,         32'hFFFF_FFFD, 32'hFFFF_FFEB, 33, 1'b1);
    applyStimulus(OP_MULHSU, 32'hFFFF_FFFF, 32'd2,         32'hFFFF_FFFF, 33, 1'b1);
    applyStimulus(OP_DIV,    32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFD, 33, 1'b1);
    applyStimulus(OP_REM,    32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFF, 33, 1'b1);
    applyStimulus(OP_DIVU,   32'd100,       32'd7,         32'd14,        33, 1'b1);
    applyStimulus(OP_REMU,   32'd100,       32'd7,         32'd2,         33, 1'b1);

    // Fixed-answer divide corner cases
    applyStimulus(OP_DIV,  32'd5,         32'd0,         32'hFFFF_FFFF, 1, 1'b1);
    applyStimulus(OP_REM,  32'd5,         32'd0,         32'd5,         1, 1'b1);
    applyStimulus(OP_DIVU, 32'd5,         32'd0,         32'hFFFF_FFFF, 1, 1'b1);
    applyStimulus(OP_REMU, 32'd5,         32'd0,         32'd5,         1, 1'b1);
    applyStimulus(OP_DIV,  32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1, 1'b1);
    applyStimulus(OP_REM,  32'h8000_0000, 32'hFFFF_FFFF, 32'd0,         1, 1'b1);

    // Backpressure: result must hold while out_ready stays low
    applyStimulus(OP_ADD, 32'd1, 32'd2, 32'd3, 1, 1'b0);
    bad = 0;
    repeat (10) begin
      @(negedge clk);
      if (out_valid !== 1'b1 || result !== 32'd3 || in_ready !== 1'b0) bad++;
    end
    checkOutput("backpressure_stable", 32'(bad), 32'd0);
    @(posedge clk); #1 out_ready = 1'b1;
    @(negedge clk);
    @(negedge clk);
    checkOutput("after_handoff_rdy_vld", {30'd0, in_ready, out_valid}, 32'b10);

    // Flush during a DIVU
    @(posedge clk); #1;
    op = OP_DIVU; a = 32'd1000; b = 32'd3; in_valid = 1'b1;
    @(posedge clk); #1 in_valid = 1'b0;
    repeat (4) @(posedge clk);
    @(negedge clk);
    checkOutput("busy_before_flush", 32'(busy), 32'd1);
    @(posedge clk); #1 flush = 1'b1;
    @(posedge clk); #1 flush = 1'b0;
    @(negedge clk);
    checkOutput("flush_vld_busy_rdy", {29'd0, out_valid, busy, in_ready}, 32'b001);
    bad = 0;
    repeat (40) begin
      @(negedge clk);
      if (out_valid) bad++;
    end
    checkOutput("flush_no_out_valid", 32'(bad), 32'd0);

    // Flush coincident with accept cancels the accept
    @(posedge clk); #1;
    op = OP_ADD; a = 32'd4; b = 32'd4; in_valid = 1'b1; flush = 1'b1;
    @(posedge clk); #1 in_valid = 1'b0; flush = 1'b0;
    @(negedge clk);
    checkOutput("flush_accept_vld_busy_rdy", {29'd0, out_valid, busy, in_ready}, 32'b001);

    // Reset in the middle of a MUL
    @(posedge clk); #1;
    op = OP_MUL; a = 32'd3; b = 32'd5; in_valid = 1'b1;
    @(posedge clk); #1 in_valid = 1'b0;
    repeat (10) @(posedge clk);
    #1 rst_n = 1'b0;
    @(posedge clk);
    @(negedge clk);
    checkOutput("midreset_rdy_vld_busy", {29'd0, in_ready, out_valid, busy}, 32'b100);
    checkOutput("midreset_result", result, 32'd0);
    @(posedge clk); #1 rst_n = 1'b1;
    bad = 0;
    repeat (40) begin
      @(negedge clk);
      if (out_valid) bad++;
    end
    checkOutput("midreset_no_out_valid", 32'(bad), 32'd0);

    // Randomised multiply/divide against the native-arithmetic model
    for (int i = 0; i < 12; i++) begin
      o = 5'(10 + $urandom_range(0, 7));
      x = $urandom;
      y = $urandom;
      if (i % 3 == 0) y = $urandom_range(1, 20);
      if (i % 4 == 1) x = $urandom_range(0, 1000);
      applyStimulus(o, x, y, modelOp(o, x, y), modelLat(o, x, y), 1'b1);
    end

    repeat (3) @(negedge clk);
    checkOutput("scoreboard_drained", 32'(expq.size()), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
